// File: rtl/bf_spi_pkg.sv
// Shared constants for the BF SPI register slave: FSM encoding, command byte
// layout and register map limits.
package bf_spi_pkg;

    localparam int NREG = 16;
    localparam logic [3:0] VERSION_ADDR = 4'hF;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CMD     = 2'd1;
    localparam logic [1:0] ST_DATA    = 2'd2;
    localparam logic [1:0] ST_WAIT_CS = 2'd3;

    localparam int CMD_RW_BIT   = 7;
    localparam int CMD_ADDR_MSB = 6;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for bringing SPI pins into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // No reset: the FSM must see the true pin level while rst is still held.
    always_ff @(posedge clk) begin
        meta_q <= d;
        sync_q <= meta_q;
    end

    assign q = sync_q;

endmodule

// File: rtl/bf_spi_reg_slave.sv
// SPI mode-0 register slave for the BF SPI port: 16 byte registers, read-only VERSION at 0x0F.
// Define BF_SPI_AUTOINC_EN to step the address after every data byte of a frame.
module bf_spi_reg_slave
    import bf_spi_pkg::*;
#(
    parameter logic [7:0] VERSION = 8'hB6,
    parameter int         NREG    = bf_spi_pkg::NREG
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                SCK,
    input  logic                MOSI_BF,
    input  logic                fs3,
    output logic                MISO_buf,
    output logic [8*NREG-1:0]   reg_out,
    output logic                wr_stb,
    output logic [3:0]          wr_addr,
    output logic [7:0]          wr_data
);

    logic sck_s, mosi_s, fs3_s;
    logic sck_prev_q, fs3_prev_q;
    logic sck_rise, sck_fall, fs3_fall;

    logic [1:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic [6:0] tx_q, tx_d;
    logic       rw_q, rw_d;
    logic [6:0] addr_q, addr_d;
    logic       miso_q, miso_d;
    logic       wr_stb_q, wr_stb_d;
    logic [3:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic [7:0] regs_q [NREG];
    logic [7:0] regs_d [NREG];

    logic [7:0] rx_byte;
    logic [7:0] rd_val;
    logic       writable;

    sync_2ff u_sync_sck  (.clk(clk), .d(SCK),     .q(sck_s));
    sync_2ff u_sync_mosi (.clk(clk), .d(MOSI_BF), .q(mosi_s));
    sync_2ff u_sync_fs3  (.clk(clk), .d(fs3),     .q(fs3_s));

    always_ff @(posedge clk) begin
        sck_prev_q <= sck_s;
        fs3_prev_q <= fs3_s;
    end

    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign fs3_fall = fs3_prev_q & ~fs3_s;
    assign rx_byte  = {shift_q, mosi_s};
    assign writable = (addr_q < 7'(NREG)) && (addr_q[3:0] != VERSION_ADDR);

    always_comb begin
        rd_val = regs_q[addr_q[3:0]];
        if (addr_q >= 7'(NREG)) begin
            rd_val = 8'h00;
        end else if (addr_q[3:0] == VERSION_ADDR) begin
            rd_val = VERSION;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        miso_d    = miso_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        regs_d    = regs_q;

        if (fs3_s) begin
            // Deselect aborts everything, including a half-received byte.
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            miso_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    miso_d = 1'b0;
                    if (fs3_fall) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_CMD: begin
                    miso_d = 1'b0;
                    if (sck_rise) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rw_d    = rx_byte[CMD_RW_BIT];
                            addr_d  = rx_byte[CMD_ADDR_MSB:0];
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (sck_rise) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (!rw_q && writable) begin
                                regs_d[addr_q[3:0]] = rx_byte;
                                wr_stb_d  = 1'b1;
                                wr_addr_d = addr_q[3:0];
                                wr_data_d = rx_byte;
                            end
`ifdef BF_SPI_AUTOINC_EN
                            addr_d = addr_q + 7'd1;
`else
                            addr_d = addr_q;
`endif
                        end
                    end else if (sck_fall && rw_q) begin
                        // MSB goes straight to the pin; tx_q holds the remaining bits.
                        if (bit_cnt_q == 3'd0) begin
                            miso_d = rd_val[7];
                            tx_d   = rd_val[6:0];
                        end else begin
                            miso_d = tx_q[6];
                            tx_d   = {tx_q[5:0], 1'b0};
                        end
                    end
                    if (!rw_q) begin
                        miso_d = 1'b0;
                    end
                end
                ST_WAIT_CS: begin
                    miso_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    miso_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // A frame already in progress at reset release is skipped entirely.
            state_q   <= fs3_s ? ST_IDLE : ST_WAIT_CS;
            bit_cnt_q <= 3'd0;
            shift_q   <= 7'd0;
            tx_q      <= 7'd0;
            rw_q      <= 1'b0;
            addr_q    <= 7'd0;
            miso_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= 4'd0;
            wr_data_q <= 8'd0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            miso_q    <= miso_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            regs_q    <= regs_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg_out
            assign reg_out[8*gi +: 8] = regs_q[gi];
        end
    endgenerate

    assign MISO_buf = miso_q;
    assign wr_stb   = wr_stb_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_bf_spi_reg_slave.sv
// Directed bench for bf_spi_reg_slave: SPI mode-0 master model plus write-strobe monitor.
module tb_bf_spi_reg_slave;

    localparam int HALF = 80;

    logic         clk = 1'b0;
    logic         rst;
    logic         SCK;
    logic         MOSI_BF;
    logic         fs3;
    logic         MISO_buf;
    logic [127:0] reg_out;
    logic         wr_stb;
    logic [3:0]   wr_addr;
    logic [7:0]   wr_data;

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    int base;
    logic [3:0] last_addr = 4'd0;
    logic [7:0] last_data = 8'd0;

    logic [7:0] tx_buf [4];
    logic [7:0] rx_buf [4];

    bf_spi_reg_slave dut (
        .clk      (clk),
        .rst      (rst),
        .SCK      (SCK),
        .MOSI_BF  (MOSI_BF),
        .fs3      (fs3),
        .MISO_buf (MISO_buf),
        .reg_out  (reg_out),
        .wr_stb   (wr_stb),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_stb) begin
            wr_cnt++;
            last_addr = wr_addr;
            last_data = wr_data;
            check_eq("stb_regout", 128'(reg_out[8*wr_addr +: 8]), 128'(wr_data));
        end
    end

    task automatic set_tx(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
        tx_buf[0] = b0;
        tx_buf[1] = b1;
        tx_buf[2] = b2;
        tx_buf[3] = b3;
        for (int k = 0; k < 4; k++) rx_buf[k] = 8'h00;
    endtask

    task automatic spi_bits(input int first, input int count);
        for (int i = first; i < first + count; i++) begin
            MOSI_BF = tx_buf[i/8][7-(i%8)];
            #(HALF);
            SCK = 1'b1;
            rx_buf[i/8][7-(i%8)] = MISO_buf;
            #(HALF);
            SCK = 1'b0;
        end
    endtask

    task automatic spi_frame(input int nbits);
        fs3 = 1'b0;
        #(HALF);
        spi_bits(0, nbits);
        #(HALF);
        fs3 = 1'b1;
        #(8*HALF);
        $display("[TB] frame bits=%0d tx=%h %h %h %h rx=%h %h %h %h wr_cnt=%0d",
                 nbits, tx_buf[0], tx_buf[1], tx_buf[2], tx_buf[3],
                 rx_buf[0], rx_buf[1], rx_buf[2], rx_buf[3], wr_cnt);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        SCK = 1'b0;
        MOSI_BF = 1'b0;
        fs3 = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_reg_out", reg_out, 128'h0);
        check_eq("rst_wr_stb", 128'(wr_stb), 128'h0);
        check_eq("rst_wr_addr", 128'(wr_addr), 128'h0);
        check_eq("rst_wr_data", 128'(wr_data), 128'h0);
        check_eq("rst_miso", 128'(MISO_buf), 128'h0);

        // Basic write
        base = wr_cnt;
        set_tx(8'h03, 8'h5A, 8'h00, 8'h00);
        spi_frame(16);
        check_eq("wr3_count", 128'(wr_cnt - base), 128'd1);
        check_eq("wr3_addr", 128'(last_addr), 128'h3);
        check_eq("wr3_data", 128'(last_data), 128'h5A);
        check_eq("wr3_reg", 128'(reg_out[31:24]), 128'h5A);
        check_eq("wr3_miso", 128'(rx_buf[1]), 128'h00);

        // VERSION read
        set_tx(8'h8F, 8'h00, 8'h00, 8'h00);
        spi_frame(16);
        check_eq("rdver_cmd", 128'(rx_buf[0]), 128'h00);
        check_eq("rdver_data", 128'(rx_buf[1]), 128'hB6);

        // Two-byte read of register 3
        set_tx(8'h83, 8'h00, 8'h00, 8'h00);
        spi_frame(24);
        check_eq("rd3_b1", 128'(rx_buf[1]), 128'h5A);
`ifdef BF_SPI_AUTOINC_EN
        check_eq("rd3_b2", 128'(rx_buf[2]), 128'h00);
`else
        check_eq("rd3_b2", 128'(rx_buf[2]), 128'h5A);
`endif

        // Out-of-range read and write
        set_tx(8'hA0, 8'h00, 8'h00, 8'h00);
        spi_frame(16);
        check_eq("rd20_data", 128'(rx_buf[1]), 128'h00);
        base = wr_cnt;
        set_tx(8'h20, 8'hFF, 8'h00, 8'h00);
        spi_frame(16);
        check_eq("wr20_count", 128'(wr_cnt - base), 128'd0);
        check_eq("wr20_regs", reg_out, 128'h5A << 24);

        // VERSION address is not writable
        base = wr_cnt;
        set_tx(8'h0F, 8'hC3, 8'h00, 8'h00);
        spi_frame(16);
        check_eq("wrF_count", 128'(wr_cnt - base), 128'd0);
        check_eq("wrF_reg", 128'(reg_out[127:120]), 128'h00);

        // Multi-byte write starting at 0x0E
        base = wr_cnt;
        set_tx(8'h0E, 8'h11, 8'h22, 8'h33);
        spi_frame(32);
`ifdef BF_SPI_AUTOINC_EN
        check_eq("wrE_count", 128'(wr_cnt - base), 128'd1);
        check_eq("wrE_reg", 128'(reg_out[119:112]), 128'h11);
`else
        check_eq("wrE_count", 128'(wr_cnt - base), 128'd3);
        check_eq("wrE_reg", 128'(reg_out[119:112]), 128'h33);
        check_eq("wrE_last", 128'(last_data), 128'h33);
`endif
        check_eq("wrE_regF", 128'(reg_out[127:120]), 128'h00);

        // Frame aborted after 5 data bits
        base = wr_cnt;
        set_tx(8'h05, 8'h77, 8'h00, 8'h00);
        spi_frame(13);
        check_eq("abort_count", 128'(wr_cnt - base), 128'd0);
        check_eq("abort_reg", 128'(reg_out[47:40]), 128'h00);
        base = wr_cnt;
        spi_frame(16);
        check_eq("after_abort_count", 128'(wr_cnt - base), 128'd1);
        check_eq("after_abort_reg", 128'(reg_out[47:40]), 128'h77);

        // Reset in the middle of a frame, released with fs3 still low
        set_tx(8'h02, 8'h44, 8'h99, 8'h00);
        fs3 = 1'b0;
        #(HALF);
        spi_bits(0, 11);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        base = wr_cnt;
        check_eq("midrst_regs", reg_out, 128'h0);
        spi_bits(11, 13);
        #(HALF);
        fs3 = 1'b1;
        #(8*HALF);
        $display("[TB] frame with mid-frame reset done wr_cnt=%0d", wr_cnt);
        check_eq("midrst_count", 128'(wr_cnt - base), 128'd0);
        check_eq("midrst_regs_after", reg_out, 128'h0);
        base = wr_cnt;
        set_tx(8'h02, 8'h44, 8'h00, 8'h00);
        spi_frame(16);
        check_eq("postrst_count", 128'(wr_cnt - base), 128'd1);
        check_eq("postrst_reg", 128'(reg_out[23:16]), 128'h44);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
